key_input_ctrl: RTL and testbench



---
 rtl/key_input_ctrl_pkg.sv | 44 ++++
 rtl/key_input_ctrl_repeat.sv | 90 +++++++++
 rtl/key_input_ctrl.sv | 143 ++++++++++++++
 tb/tb_key_input_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_input_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_input_ctrl_pkg
// Description : Shared types, request bit positions and keycode helpers for
//               the keyboard-to-move-request front end.
// Revision    : 1.0 - initial release
// ============================================================================
package key_input_ctrl_pkg;

    // Repeat engine states for the left/right/down keys
    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_t;

    // Request bit positions; these line up with block_logic's can_move[4:0]
    localparam int REQ_LEFT  = 0;
    localparam int REQ_RIGHT = 1;
    localparam int REQ_DOWN  = 2;
    localparam int REQ_ROT_L = 3;
    localparam int REQ_ROT_R = 4;
    localparam int REQ_W     = 5;

    // Frame counter width inside each repeat engine
    localparam int CNT_W = 6;

    // HID keyboards report 0x01 in every slot when too many keys are down
    localparam logic [7:0] KC_ROLLOVER = 8'h01;

    // True when any of the four key slots carries the given HID code
    function automatic logic kc_has(input logic [31:0] kc, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (kc[8*i +: 8] == code) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage : key_input_ctrl_pkg
`default_nettype wire

// File: rtl/key_input_ctrl_repeat.sv
`default_nettype none
// ============================================================================
// Module      : key_repeat
// Description : Frame-paced auto-shift engine for one key. Emits on the first
//               tick a key is held, optionally waits delay_frames, then emits
//               every period_frames ticks while the key stays held.
// Ports       : Clk           in  system clock
//               Reset         in  asynchronous active-high reset
//               tick          in  one-cycle frame pulse; state only moves here
//               held          in  key is held (already cancelled/filtered)
//               delay_frames  in  ticks before repeating starts (>=2)
//               period_frames in  ticks between repeats (>=1)
//               use_delay     in  0 skips DELAY and repeats straight away
//               emit          out one-cycle request pulse (only on tick)
// Revision    : 1.0 - initial release
// ============================================================================
module key_repeat
    import key_input_ctrl_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             tick,
    input  logic             held,
    input  logic [CNT_W-1:0] delay_frames,
    input  logic [CNT_W-1:0] period_frames,
    input  logic             use_delay,
    output logic             emit
);

    rep_state_t       r_state;
    rep_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= REP_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter holds the number of ticks already spent in the current
    // state, so comparing the pre-increment value against N-1 puts the
    // emit exactly N ticks after entering the state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        emit        = 1'b0;
        if (tick) begin
            if (!held) begin
                w_state_nxt = REP_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                case (r_state)
                    REP_IDLE: begin
                        emit        = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = use_delay ? REP_DELAY : REP_REPEAT;
                    end
                    REP_DELAY: begin
                        if (r_cnt == delay_frames - CNT_W'(1)) begin
                            emit        = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = REP_REPEAT;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                    REP_REPEAT: begin
                        if (r_cnt == period_frames - CNT_W'(1)) begin
                            emit      = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = REP_IDLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

endmodule : key_repeat
`default_nettype wire

// File: rtl/key_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_input_ctrl
// Description : Converts the 32-bit HID keycode word into pending move
//               requests for block_logic. Left/right use DAS/ARR auto-shift,
//               down repeats at DROP_FRAMES, rotations fire on press only.
// Ports       : Clk        in  1   system clock
//               Reset      in  1   asynchronous active-high reset
//               frame_clk  in  1   VGA vertical sync; rising edge = one tick
//               keycode    in  32  four HID key slots, 8'h00 = empty
//               req_ack    in  1   block_logic consumed the pending requests
//               req        out 5   pending requests (left,right,down,rotL,rotR)
//               req_valid  out 1   any request pending
// Revision    : 1.0 - initial release
// ============================================================================
module key_input_ctrl
    import key_input_ctrl_pkg::*;
#(
    parameter int         DAS_FRAMES  = 16,
    parameter int         ARR_FRAMES  = 6,
    parameter int         DROP_FRAMES = 3,
    parameter logic [7:0] KC_LEFT     = 8'h50,
    parameter logic [7:0] KC_RIGHT    = 8'h4F,
    parameter logic [7:0] KC_DOWN     = 8'h51,
    parameter logic [7:0] KC_ROT_L    = 8'h1D,
    parameter logic [7:0] KC_ROT_R    = 8'h1B
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic [31:0]      keycode,
    input  logic             req_ack,
    output logic [REQ_W-1:0] req,
    output logic             req_valid
);

    localparam logic [CNT_W-1:0] c_DAS  = CNT_W'(DAS_FRAMES);
    localparam logic [CNT_W-1:0] c_ARR  = CNT_W'(ARR_FRAMES);
    localparam logic [CNT_W-1:0] c_DROP = CNT_W'(DROP_FRAMES);

    logic [31:0]      r_kc_q;
    logic             r_frame_d1;
    logic             r_frame_d2;
    logic             r_rot_l_prev;
    logic             r_rot_r_prev;
    logic [REQ_W-1:0] r_req;

    logic             w_tick;
    logic             w_rollover;
    logic             w_raw_left, w_raw_right, w_raw_down, w_raw_rot_l, w_raw_rot_r;
    logic             w_held_left, w_held_right, w_held_down, w_held_rot_l, w_held_rot_r;
    logic             w_emit_left, w_emit_right, w_emit_down;
    logic [REQ_W-1:0] w_emit;

    // frame_clk is asynchronous to Clk; the first flop synchronises and
    // the pair yields a single-cycle pulse per rising edge.
    assign w_tick = r_frame_d1 & ~r_frame_d2;

    // Key matching on the registered keycode word
    assign w_rollover  = kc_has(r_kc_q, KC_ROLLOVER);
    assign w_raw_left  = kc_has(r_kc_q, KC_LEFT);
    assign w_raw_right = kc_has(r_kc_q, KC_RIGHT);
    assign w_raw_down  = kc_has(r_kc_q, KC_DOWN);
    assign w_raw_rot_l = kc_has(r_kc_q, KC_ROT_L);
    assign w_raw_rot_r = kc_has(r_kc_q, KC_ROT_R);

    // Opposing keys cancel each other; a rollover report releases everything
    assign w_held_left  = ~w_rollover & w_raw_left  & ~w_raw_right;
    assign w_held_right = ~w_rollover & w_raw_right & ~w_raw_left;
    assign w_held_down  = ~w_rollover & w_raw_down;
    assign w_held_rot_l = ~w_rollover & w_raw_rot_l & ~w_raw_rot_r;
    assign w_held_rot_r = ~w_rollover & w_raw_rot_r & ~w_raw_rot_l;

    key_repeat u_rep_left (
        .Clk           (Clk),
        .Reset         (Reset),
        .tick          (w_tick),
        .held          (w_held_left),
        .delay_frames  (c_DAS),
        .period_frames (c_ARR),
        .use_delay     (1'b1),
        .emit          (w_emit_left)
    );

    key_repeat u_rep_right (
        .Clk           (Clk),
        .Reset         (Reset),
        .tick          (w_tick),
        .held          (w_held_right),
        .delay_frames  (c_DAS),
        .period_frames (c_ARR),
        .use_delay     (1'b1),
        .emit          (w_emit_right)
    );

    // Soft drop repeats immediately; delay_frames is ignored with use_delay=0
    key_repeat u_rep_down (
        .Clk           (Clk),
        .Reset         (Reset),
        .tick          (w_tick),
        .held          (w_held_down),
        .delay_frames  (c_DROP),
        .period_frames (c_DROP),
        .use_delay     (1'b0),
        .emit          (w_emit_down)
    );

    always_comb begin
        w_emit            = '0;
        w_emit[REQ_LEFT]  = w_emit_left;
        w_emit[REQ_RIGHT] = w_emit_right;
        w_emit[REQ_DOWN]  = w_emit_down;
        w_emit[REQ_ROT_L] = w_tick & w_held_rot_l & ~r_rot_l_prev;
        w_emit[REQ_ROT_R] = w_tick & w_held_rot_r & ~r_rot_r_prev;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_kc_q       <= '0;
            r_frame_d1   <= 1'b0;
            r_frame_d2   <= 1'b0;
            r_rot_l_prev <= 1'b0;
            r_rot_r_prev <= 1'b0;
            r_req        <= '0;
        end else begin
            r_kc_q     <= keycode;
            r_frame_d1 <= frame_clk;
            r_frame_d2 <= r_frame_d1;
            // Rotation history is per tick, not per clock
            if (w_tick) begin
                r_rot_l_prev <= w_held_rot_l;
                r_rot_r_prev <= w_held_rot_r;
            end
            // New emits are OR-ed after the ack clear so they are never lost
            r_req <= (req_ack ? '0 : r_req) | w_emit;
        end
    end

    assign req       = r_req;
    assign req_valid = |r_req;

endmodule : key_input_ctrl
`default_nettype wire

// File: tb/tb_key_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_input_ctrl
// Description : Directed self-checking bench for key_input_ctrl
//               (DAS=16, ARR=6, DROP=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_input_ctrl;

    logic        Clk;
    logic        Reset;
    logic        frame_clk;
    logic [31:0] keycode;
    logic        req_ack;
    logic [4:0]  req;
    logic        req_valid;

    int checks = 0;
    int errors = 0;

    key_input_ctrl #(
        .DAS_FRAMES  (16),
        .ARR_FRAMES  (6),
        .DROP_FRAMES (3)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .req_ack   (req_ack),
        .req       (req),
        .req_valid (req_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One frame: rising edge, a few cycles high, a few low. Returns on a
    // negedge with the tick fully processed.
    task automatic frame();
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic ack();
        req_ack = 1'b1;
        @(negedge Clk);
        req_ack = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (req !== 5'b00000) begin
            $display("FAIL reset_req: req=%b expected=%b", req, 5'b00000);
            errors++;
        end
        checks++;
        if (req_valid !== 1'b0) begin
            $display("FAIL reset_valid: req_valid=%b expected=0", req_valid);
            errors++;
        end
    endtask

    task automatic test_tap();
        keycode = 32'h0000_0050;
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);                 // tick cycle: nothing registered yet
        checks++;
        if (req !== 5'b00000) begin
            $display("FAIL tap_tick_cycle: req=%b expected=%b", req, 5'b00000);
            errors++;
        end
        @(negedge Clk);
        checks++;
        if (req !== 5'b00001 || req_valid !== 1'b1) begin
            $display("FAIL tap_emit: req=%b valid=%b expected=%b valid=1", req, req_valid, 5'b00001);
            errors++;
        end
        keycode = 32'h0;
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        frame();
        checks++;
        if (req !== 5'b00001) begin
            $display("FAIL tap_hold_pending: req=%b expected=%b", req, 5'b00001);
            errors++;
        end
        ack();
        checks++;
        if (req !== 5'b00000 || req_valid !== 1'b0) begin
            $display("FAIL tap_ack_clear: req=%b valid=%b expected=%b valid=0", req, req_valid, 5'b00000);
            errors++;
        end
    endtask

    task automatic test_hold_right();
        logic [4:0] exp;
        keycode = 32'h0000_004F;
        for (int t = 0; t < 40; t++) begin
            frame();
            exp = (t == 0 || t == 16 || t == 22 || t == 28 || t == 34) ? 5'b00010 : 5'b00000;
            checks++;
            if (req !== exp) begin
                $display("FAIL hold_right_t%0d: req=%b expected=%b", t, req, exp);
                errors++;
            end
            ack();
        end
        keycode = 32'h0;
        frame();
        checks++;
        if (req !== 5'b00000) begin
            $display("FAIL right_release: req=%b expected=%b", req, 5'b00000);
            errors++;
        end
        keycode = 32'h0000_004F;
        frame();
        checks++;
        if (req !== 5'b00010) begin
            $display("FAIL right_repress: req=%b expected=%b", req, 5'b00010);
            errors++;
        end
        ack();
        keycode = 32'h0;
        frame();
    endtask

    task automatic test_down_and_cancel();
        logic [4:0] exp;
        keycode = 32'h0000_0051;
        for (int t = 0; t < 10; t++) begin
            frame();
            exp = (t % 3 == 0) ? 5'b00100 : 5'b00000;
            checks++;
            if (req !== exp) begin
                $display("FAIL hold_down_t%0d: req=%b expected=%b", t, req, exp);
                errors++;
            end
            ack();
        end
        keycode = 32'h0000_4F50;
        for (int t = 0; t < 5; t++) begin
            frame();
            checks++;
            if (req !== 5'b00000) begin
                $display("FAIL lr_cancel_t%0d: req=%b expected=%b", t, req, 5'b00000);
                errors++;
            end
        end
        keycode = 32'h0;
        frame();
    endtask

    task automatic test_rotation();
        logic [4:0] exp;
        keycode = 32'h0000_001B;
        for (int t = 0; t < 10; t++) begin
            frame();
            exp = (t == 0) ? 5'b10000 : 5'b00000;
            checks++;
            if (req !== exp) begin
                $display("FAIL rot_hold_t%0d: req=%b expected=%b", t, req, exp);
                errors++;
            end
            ack();
        end
        keycode = 32'h0;
        frame();
        checks++;
        if (req !== 5'b00000) begin
            $display("FAIL rot_release: req=%b expected=%b", req, 5'b00000);
            errors++;
        end
        keycode = 32'h0000_001B;
        frame();
        checks++;
        if (req !== 5'b10000) begin
            $display("FAIL rot_repress: req=%b expected=%b", req, 5'b10000);
            errors++;
        end
        ack();
        keycode = 32'h0;
        frame();
    endtask

    task automatic test_ack_with_emit();
        keycode = 32'h0000_0050;
        frame();                        // left pending
        keycode = 32'h0000_001D;        // release left, press Z
        repeat (2) @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);                 // tick cycle: ack lands on the same edge
        req_ack = 1'b1;
        @(negedge Clk);
        req_ack = 1'b0;
        checks++;
        if (req !== 5'b01000) begin
            $display("FAIL ack_with_emit: req=%b expected=%b", req, 5'b01000);
            errors++;
        end
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        ack();
        keycode = 32'h0;
        frame();
    endtask

    task automatic test_reset_mid_and_rollover();
        keycode = 32'h0000_1D50;        // left + rot_left
        frame();
        repeat (3) frame();             // left sits in DELAY
        checks++;
        if (req !== 5'b01001) begin
            $display("FAIL pre_reset_pending: req=%b expected=%b", req, 5'b01001);
            errors++;
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (req !== 5'b00000 || req_valid !== 1'b0) begin
            $display("FAIL async_reset: req=%b valid=%b expected=%b valid=0", req, req_valid, 5'b00000);
            errors++;
        end
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        frame();
        checks++;
        if (req !== 5'b01001) begin
            $display("FAIL post_reset_press: req=%b expected=%b", req, 5'b01001);
            errors++;
        end
        ack();
        keycode = 32'h0;
        frame();
        keycode = 32'h0100_0050;        // rollover byte with left
        for (int t = 0; t < 2; t++) begin
            frame();
            checks++;
            if (req !== 5'b00000) begin
                $display("FAIL rollover_t%0d: req=%b expected=%b", t, req, 5'b00000);
                errors++;
            end
        end
        keycode = 32'h0000_0050;
        frame();
        checks++;
        if (req !== 5'b00001) begin
            $display("FAIL after_rollover: req=%b expected=%b", req, 5'b00001);
            errors++;
        end
        ack();
        keycode = 32'h0;
        frame();
    endtask

    initial begin
        Reset     = 1'b1;
        frame_clk = 1'b0;
        keycode   = 32'h0;
        req_ack   = 1'b0;
        repeat (3) @(negedge Clk);
        test_reset();
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        test_tap();
        test_hold_right();
        test_down_and_cancel();
        test_rotation();
        test_ack_with_emit();
        test_reset_mid_and_rollover();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_key_input_ctrl
`default_nettype wire
